// File: rtl/dff_shift_bank_if.sv
// dff_shift_bank_if: control, data and status bundle for dff_shift_bank
interface dff_shift_bank_if #(
    parameter int WIDTH = 8,
    parameter int CW = $clog2(WIDTH + 1)
);
    logic             clr, set, en, start, sin, sout, busy, done;
    logic [1:0]       mode;
    logic [WIDTH-1:0] d, q;
    logic [CW-1:0]    count;
    modport master(output clr, set, en, mode, d, sin, start, count, input q, sout, busy, done);
    modport slave(input clr, set, en, mode, d, sin, start, count, output q, sout, busy, done);
endinterface

// File: rtl/dff_shift_bank.sv
// dff_shift_bank: shift/load register with single-step ops and counted burst shifts
module dff_shift_bank #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    parameter bit               ROTATE  = 1'b0,
    parameter int               CW      = $clog2(WIDTH + 1)
) (
    input logic             clk,
    input logic             rst,
    dff_shift_bank_if.slave bus
);
    typedef enum logic {IDLE, BURST} state_t;
    state_t           state, state_d;
    logic [WIDTH-1:0] q, q_d, shr, shl;
    logic [CW-1:0]    rem, rem_d;
    logic             dir, dir_d, done, done_d, accept, left;
    assign shr    = {ROTATE ? q[0] : bus.sin, q[WIDTH-1:1]};
    assign shl    = {q[WIDTH-2:0], ROTATE ? q[WIDTH-1] : bus.sin};
    assign accept = state == IDLE && bus.start && bus.mode[1] != bus.mode[0] && bus.count != '0;
    // dir latches left (1) or right (0) for the whole burst
    assign left     = state == BURST ? dir : bus.mode == 2'b10;
    assign bus.q    = q;
    assign bus.sout = left ? q[WIDTH-1] : q[0];
    assign bus.busy = state == BURST;
    assign bus.done = done;
    always_comb begin
        state_d = state;
        q_d     = q;
        rem_d   = rem;
        dir_d   = dir;
        done_d  = 1'b0;
        if (bus.clr || bus.set) begin
            state_d = IDLE;
            rem_d   = '0;
            q_d     = {WIDTH{~bus.clr}};
        end else if (state == BURST) begin
            q_d   = dir ? shl : shr;
            rem_d = rem - CW'(1);
            if (rem == CW'(1)) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
        end else if (accept) begin
            state_d = BURST;
            dir_d   = bus.mode[1];
            rem_d   = bus.count > CW'(WIDTH) ? CW'(WIDTH) : bus.count;
        end else if (bus.en) begin
            q_d = bus.mode == 2'b11 ? bus.d : bus.mode == 2'b10 ? shl : bus.mode == 2'b01 ? shr : q;
        end
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            q     <= RST_VAL;
            rem   <= '0;
            dir   <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_d;
            q     <= q_d;
            rem   <= rem_d;
            dir   <= dir_d;
            done  <= done_d;
        end
    end
endmodule
